// File: rtl/stage_id_hazard.sv
// Decode stage: register bank with write-through, MIPS decode, load-use
// stall detection, flush/bubble insertion and a registered ID/EX bundle.
module stage_id_hazard #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_id,
  input  logic              valid_id,
  input  logic              isJumped,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  output logic              stall_if,
  output logic              valid_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [3:0]        aluOp,
  output logic              isJump,
  output logic              isNotConditional,
  output logic              isEq,
  output logic              memWrite,
  output logic              memRead,
  output logic              aluSrc,
  output logic              regDst,
  output logic [1:0]        wbi,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] extendedInstr,
  output logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] rt,
  output logic [ADDR_W-1:0] rd,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [3:0]        aluOp;
    logic              isJump;
    logic              isNotCond;
    logic              isEq;
    logic              memWrite;
    logic              memRead;
    logic              aluSrc;
    logic              regDst;
    logic [1:0]        wbi;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] ext;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
  } idEx_t;

  idEx_t cur;
  idEx_t nxt;
  idEx_t dec;

  logic [5:0]        opc;
  logic [ADDR_W-1:0] rsA;
  logic [ADDR_W-1:0] rtA;
  logic [ADDR_W-1:0] rdA;
  logic              wrEn;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic              usesRt;
  logic              hz;

  logic [DATA_W-1:0] bank [REG_COUNT];

  assign opc  = instr[31:26];
  assign rsA  = ADDR_W'(instr[25:21]);
  assign rtA  = ADDR_W'(instr[20:16]);
  assign rdA  = ADDR_W'(instr[15:11]);
  assign wrEn = regWrite && (writeAddr != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        bank[i] <= '0;
      end
    end else if (wrEn) begin
      bank[writeAddr] <= writeData;
    end
  end

  // WB write in the same cycle is visible to the read ports
  always_comb begin
    rsData = bank[rsA];
    rtData = bank[rtA];
    if (wrEn && writeAddr == rsA) rsData = writeData;
    if (wrEn && writeAddr == rtA) rtData = writeData;
    if (rsA == '0) rsData = '0;
    if (rtA == '0) rtData = '0;
  end

  always_comb begin
    dec       = '0;
    usesRt    = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = pc_id;
    dec.reg1  = rsData;
    dec.reg2  = rtData;
    dec.ext   = DATA_W'($signed(instr[15:0]));
    dec.rs    = rsA;
    dec.rt    = rtA;
    dec.rd    = rdA;
    unique case (1'b1)
      opc == OP_R: begin
        dec.regDst = 1'b1;
        dec.wbi    = WB_ALU;
        usesRt     = 1'b1;
      end
      opc == OP_LW: begin
        dec.aluOp   = ALU_ADD;
        dec.memRead = 1'b1;
        dec.aluSrc  = 1'b1;
        dec.wbi     = WB_MEM;
      end
      opc == OP_SW: begin
        dec.aluOp    = ALU_ADD;
        dec.memWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        usesRt       = 1'b1;
      end
      opc == OP_BEQ: begin
        dec.aluOp  = ALU_SUB;
        dec.isJump = 1'b1;
        dec.isEq   = 1'b1;
        usesRt     = 1'b1;
      end
      opc == OP_BNE: begin
        dec.aluOp  = ALU_SUB;
        dec.isJump = 1'b1;
        usesRt     = 1'b1;
      end
      opc == OP_J: begin
        dec.isJump    = 1'b1;
        dec.isNotCond = 1'b1;
      end
      opc == OP_ADDI: begin
        dec.aluOp  = ALU_ADD;
        dec.aluSrc = 1'b1;
        dec.wbi    = WB_ALU;
      end
      opc == OP_ANDI: begin
        dec.aluOp  = ALU_AND;
        dec.aluSrc = 1'b1;
        dec.wbi    = WB_ALU;
      end
      opc == OP_ORI: begin
        dec.aluOp  = ALU_OR;
        dec.aluSrc = 1'b1;
        dec.wbi    = WB_ALU;
      end
      opc == OP_SLTI: begin
        dec.aluOp  = ALU_SLT;
        dec.aluSrc = 1'b1;
        dec.wbi    = WB_ALU;
      end
      default: dec = '0;
    endcase
  end

  assign hz = valid_id && cur.valid && cur.memRead && (cur.rt != '0)
           && ((cur.rt == rsA) || (usesRt && cur.rt == rtA));
  assign stall_if = hz && !isJumped;
  assign nxt = (isJumped || stall_if || !valid_id) ? '0 : dec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur <= '0;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_if && stall_count != '1) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign valid_ex         = cur.valid;
  assign pc_ex            = cur.pc;
  assign aluOp            = cur.aluOp;
  assign isJump           = cur.isJump;
  assign isNotConditional = cur.isNotCond;
  assign isEq             = cur.isEq;
  assign memWrite         = cur.memWrite;
  assign memRead          = cur.memRead;
  assign aluSrc           = cur.aluSrc;
  assign regDst           = cur.regDst;
  assign wbi              = cur.wbi;
  assign reg1             = cur.reg1;
  assign reg2             = cur.reg2;
  assign extendedInstr    = cur.ext;
  assign rs               = cur.rs;
  assign rt               = cur.rt;
  assign rd               = cur.rd;

endmodule
